// File: rtl/riscv_lsu.sv
// Load-store unit: one request/grant/response memory transaction per load/store instruction.
// Latency: store 3 cycles minimum, load 4 cycles minimum; each cycle of withheld gnt/rvalid adds one.
// Backpressure: stalls the core from acceptance until DONE; holds data_req_o with stable payload until data_gnt_i.
module riscv_lsu (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic [31:0] lsu_addr_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_data_i,
    input  logic        lsu_req_i,
    output logic        lsu_stall_req_o,
    output logic [31:0] lsu_data_o,
    output logic        lsu_misaligned_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic        we_q;
    logic [2:0]  size_q;
    logic [31:0] wdata_q;
    logic [31:0] lsu_data_q;

    logic        size_ok;
    logic        aligned;
    logic        accept;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_ext;

    // Unsigned sizes exist only for loads.
    always_comb begin
        size_ok = 1'b0;
        aligned = 1'b0;
        case (lsu_size_i)
            LDST_B:  begin size_ok = 1'b1;      aligned = 1'b1;                end
            LDST_H:  begin size_ok = 1'b1;      aligned = ~lsu_addr_i[0];      end
            LDST_W:  begin size_ok = 1'b1;      aligned = (lsu_addr_i[1:0] == 2'b00); end
            LDST_BU: begin size_ok = ~lsu_we_i; aligned = 1'b1;                end
            LDST_HU: begin size_ok = ~lsu_we_i; aligned = ~lsu_addr_i[0];      end
            default: begin size_ok = 1'b0;      aligned = 1'b0;                end
        endcase
    end

    assign accept = (state_q == S_IDLE) && lsu_req_i && size_ok && aligned;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept)        state_d = S_REQ;
            S_REQ:  if (data_gnt_i)    state_d = we_q ? S_DONE : S_WAIT;
            S_WAIT: if (data_rvalid_i) state_d = S_DONE;
            S_DONE:                    state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata_q;
        case (size_q)
            LDST_B, LDST_BU: begin
                be_c    = 4'b0001 << addr_q[1:0];
                wdata_c = {4{wdata_q[7:0]}};
            end
            LDST_H, LDST_HU: begin
                be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wdata_q[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = wdata_q;
            end
        endcase
    end

    // Stall and misalignment are combinational on the core request, so they are
    // also gated by reset to keep every output low while arstn_i is asserted.
    always_comb begin
        lsu_stall_req_o  = 1'b0;
        lsu_misaligned_o = 1'b0;
        data_req_o       = 1'b0;
        data_we_o        = 1'b0;
        data_be_o        = 4'b0000;
        data_addr_o      = 32'h0;
        data_wdata_o     = 32'h0;
        case (state_q)
            S_IDLE: begin
                lsu_stall_req_o  = accept && arstn_i;
                lsu_misaligned_o = lsu_req_i && !(size_ok && aligned) && arstn_i;
            end
            S_REQ: begin
                lsu_stall_req_o = 1'b1;
                data_req_o      = 1'b1;
                data_we_o       = we_q;
                data_be_o       = be_c;
                data_addr_o     = {addr_q[31:2], 2'b00};
                data_wdata_o    = wdata_c;
            end
            S_WAIT:  lsu_stall_req_o = 1'b1;
            default: lsu_stall_req_o = 1'b0;
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    rbyte = data_rdata_i[7:0];
            2'd1:    rbyte = data_rdata_i[15:8];
            2'd2:    rbyte = data_rdata_i[23:16];
            default: rbyte = data_rdata_i[31:24];
        endcase
        rhalf = addr_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (size_q)
            LDST_B:  load_ext = {{24{rbyte[7]}}, rbyte};
            LDST_BU: load_ext = {24'h0, rbyte};
            LDST_H:  load_ext = {{16{rhalf[15]}}, rhalf};
            LDST_HU: load_ext = {16'h0, rhalf};
            default: load_ext = data_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            addr_q     <= 32'h0;
            we_q       <= 1'b0;
            size_q     <= 3'd0;
            wdata_q    <= 32'h0;
            lsu_data_q <= 32'h0;
        end else begin
            if (accept) begin
                addr_q  <= lsu_addr_i;
                we_q    <= lsu_we_i;
                size_q  <= lsu_size_i;
                wdata_q <= lsu_data_i;
            end
            if (state_q == S_WAIT && data_rvalid_i)
                lsu_data_q <= load_ext;
        end
    end

    assign lsu_data_o = lsu_data_q;

endmodule
